// File: rtl/call_frame_ctrl.sv
// call_frame_ctrl: spills the 15-word register-file frame to a data-memory stack on call and refills it on return.
// Optional macro CALL_FRAME_CLEAR_EN: after each save, zero the callee frame through one restore strobe.
module call_frame_ctrl #(
   parameter int unsigned       ADDR_W     = 12,
   parameter logic [ADDR_W-1:0] STACK_BASE = 12'h800,
   parameter int unsigned       MAX_FRAMES = 16,
   localparam int unsigned      DEPTH_W    = $clog2(MAX_FRAMES + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               call_req,
   input  logic               ret_req,
   input  logic [239:0]       fc_in,
   output logic [239:0]       fc_out,
   output logic               fc_restore,
   output logic               busy,
   output logic               done,
   output logic               err_overflow,
   output logic               err_underflow,
   output logic [DEPTH_W-1:0] depth,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [15:0]        mem_wdata,
   output logic               mem_we,
   output logic               mem_re,
   input  logic [15:0]        mem_rdata
);

   localparam int unsigned FRAME_WORDS = 15;
   localparam logic [3:0]  LAST_SAVE   = 4'd14;
   localparam logic [3:0]  LAST_LOAD   = 4'd15;

   if ((64'(STACK_BASE) + 64'(FRAME_WORDS * MAX_FRAMES)) > (64'd1 << ADDR_W)) begin : g_cfg_check
      $error("call_frame_ctrl: stack region exceeds the address space");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAVE,
      S_LOAD,
      S_RESTORE,
      S_DONE
`ifdef CALL_FRAME_CLEAR_EN
      , S_CLEAR
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [239:0]        snap_q, snap_d;
   logic [239:0]        fc_out_q, fc_out_d;
   logic [DEPTH_W-1:0]  depth_q, depth_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic [3:0]          rd_word;

   // LOAD lasts 16 cycles: 15 reads, the last read's data lands one cycle later
   assign rd_word = cnt_q - 4'd1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      base_d   = base_q;
      snap_d   = snap_q;
      fc_out_d = fc_out_q;
      depth_d  = depth_q;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (call_req) begin
               if (depth_q == DEPTH_W'(MAX_FRAMES)) begin
                  ovf_d = 1'b1;
               end else begin
                  snap_d  = fc_in;
                  base_d  = STACK_BASE + ADDR_W'(FRAME_WORDS * depth_q);
                  cnt_d   = '0;
                  state_d = S_SAVE;
               end
            end else if (ret_req) begin
               if (depth_q == '0) begin
                  unf_d = 1'b1;
               end else begin
                  base_d  = STACK_BASE + ADDR_W'(FRAME_WORDS * (depth_q - DEPTH_W'(1)));
                  cnt_d   = '0;
                  state_d = S_LOAD;
               end
            end
         end
         S_SAVE: begin
            if (cnt_q == LAST_SAVE) begin
               cnt_d = '0;
`ifdef CALL_FRAME_CLEAR_EN
               fc_out_d = '0;
               state_d  = S_CLEAR;
`else
               state_d  = S_DONE;
`endif
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
`ifdef CALL_FRAME_CLEAR_EN
         S_CLEAR: state_d = S_DONE;
`endif
         S_DONE: begin
            depth_d = depth_q + DEPTH_W'(1);
            state_d = S_IDLE;
         end
         S_LOAD: begin
            if (cnt_q != 4'd0) begin
               fc_out_d[{rd_word, 4'b0000} +: 16] = mem_rdata;
            end
            if (cnt_q == LAST_LOAD) begin
               cnt_d   = '0;
               state_d = S_RESTORE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESTORE: begin
            depth_d = depth_q - DEPTH_W'(1);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         base_q   <= '0;
         snap_q   <= '0;
         fc_out_q <= '0;
         depth_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         base_q   <= base_d;
         snap_q   <= snap_d;
         fc_out_q <= fc_out_d;
         depth_q  <= depth_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign mem_we = (state_q == S_SAVE);
   assign mem_re = (state_q == S_LOAD) && (cnt_q != LAST_LOAD);

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      if ((state_q == S_SAVE) || ((state_q == S_LOAD) && (cnt_q != LAST_LOAD))) begin
         mem_addr = base_q + ADDR_W'(cnt_q);
      end
      if (state_q == S_SAVE) begin
         mem_wdata = snap_q[{cnt_q, 4'b0000} +: 16];
      end
   end

`ifdef CALL_FRAME_CLEAR_EN
   assign fc_restore = (state_q == S_RESTORE) || (state_q == S_CLEAR);
`else
   assign fc_restore = (state_q == S_RESTORE);
`endif
   assign fc_out        = fc_out_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE) || (state_q == S_RESTORE) || ovf_q || unf_q;
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;
   assign depth         = depth_q;

endmodule

// File: tb/tb_call_frame_ctrl.sv
// Self-checking bench for call_frame_ctrl: operation table plus hand-written reset/overflow sequences,
// with a memory-access and restore scoreboard filled as each operation is launched.
module tb_call_frame_ctrl;

   localparam int unsigned ADDR_W = 12;
   localparam logic [11:0] BASE   = 12'h800;
   localparam int          MAXF   = 16;
`ifdef CALL_FRAME_CLEAR_EN
   localparam int          CALL_LAT = 17;
`else
   localparam int          CALL_LAT = 16;
`endif
   localparam int          RET_LAT  = 17;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          call_req, ret_req;
   logic [239:0]  fc_in, fc_out;
   logic          fc_restore, busy, done, err_overflow, err_underflow;
   logic [4:0]    depth;
   logic [11:0]   mem_addr;
   logic [15:0]   mem_wdata, mem_rdata;
   logic          mem_we, mem_re;

   always #5 clk = ~clk;

   call_frame_ctrl #(
      .ADDR_W     (ADDR_W),
      .STACK_BASE (BASE),
      .MAX_FRAMES (MAXF)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .call_req      (call_req),
      .ret_req       (ret_req),
      .fc_in         (fc_in),
      .fc_out        (fc_out),
      .fc_restore    (fc_restore),
      .busy          (busy),
      .done          (done),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow),
      .depth         (depth),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_we        (mem_we),
      .mem_re        (mem_re),
      .mem_rdata     (mem_rdata)
   );

   logic [15:0] mem [0:4095];
   initial mem_rdata = '0;
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [15:0] data;
   } mem_exp_t;

   // code: 0 call ok, 1 return ok, 2 overflow reject, 3 underflow reject
   typedef struct {
      logic        c;
      logic        r;
      logic [15:0] seed;
      int          code;
      int          pulse_at;
      string       name;
   } vec_t;

   mem_exp_t      exp_q[$];
   logic [239:0]  rq[$];
   logic [239:0]  stack [0:MAXF-1];
   int            mdepth = 0;
   int            vectors = 0;
   int            miscompares = 0;
   int            cur_n, first_mem_n, restore_n;

   function automatic void chk(input string nm, input logic [239:0] act, input logic [239:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void bad(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: event seen, expected none", nm);
   endfunction

   function automatic logic [239:0] mk_frame(input logic [15:0] seed);
      logic [239:0] f;
      f = '0;
      for (int k = 0; k < 15; k++) f[16*k +: 16] = seed + 16'(k);
      return f;
   endfunction

   task automatic check_cycle();
      mem_exp_t e;
      if (mem_we || mem_re) begin
         if (first_mem_n < 0) first_mem_n = cur_n;
         if (exp_q.size() == 0) begin
            bad("unexpected_mem_access");
         end else begin
            e = exp_q.pop_front();
            chk("mem_we", 240'(mem_we), 240'(e.we));
            chk("mem_re", 240'(mem_re), 240'(!e.we));
            chk("mem_addr", 240'(mem_addr), 240'(e.addr));
            if (e.we) chk("mem_wdata", 240'(mem_wdata), 240'(e.data));
         end
      end else begin
         chk("idle_bus", 240'({mem_addr, mem_wdata}), '0);
      end
      if (fc_restore) begin
         if (restore_n < 0) restore_n = cur_n;
         if (rq.size() == 0) bad("unexpected_fc_restore");
         else chk("fc_out", fc_out, rq.pop_front());
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cur_n++;
      check_cycle();
   endtask

   task automatic run_op(input logic c, input logic r, input logic [15:0] seed,
                         input int code, input int pulse_at, input string nm);
      logic [239:0] f;
      logic [11:0]  b;
      int           n;
      int           lat;
      f = mk_frame(seed);
      if (code == 0) begin
         b = BASE + 12'(15 * mdepth);
         for (int k = 0; k < 15; k++) exp_q.push_back('{1'b1, b + 12'(k), f[16*k +: 16]});
`ifdef CALL_FRAME_CLEAR_EN
         rq.push_back('0);
`endif
      end else if (code == 1) begin
         b = BASE + 12'(15 * (mdepth - 1));
         for (int k = 0; k < 15; k++) exp_q.push_back('{1'b0, b + 12'(k), 16'h0});
         rq.push_back(stack[mdepth-1]);
      end
      first_mem_n = -1;
      restore_n   = -1;
      cur_n       = 0;
      call_req = c;
      ret_req  = r;
      fc_in    = f;
      tick();
      call_req = 1'b0;
      ret_req  = 1'b0;
      fc_in    = ~f;
      n = 1;
      while (!done && n < 40) begin
         chk({nm, "_busy"}, 240'(busy), 240'(1));
         ret_req = (n == pulse_at);
         tick();
         n++;
      end
      ret_req = 1'b0;
      if (!done) begin
         bad({nm, "_done_timeout"});
      end else begin
         lat = (code == 0) ? CALL_LAT : (code == 1) ? RET_LAT : 1;
         chk({nm, "_latency"}, 240'(n), 240'(lat));
         chk({nm, "_err_overflow"}, 240'(err_overflow), 240'(code == 2));
         chk({nm, "_err_underflow"}, 240'(err_underflow), 240'(code == 3));
         chk({nm, "_busy_at_done"}, 240'(busy), 240'(code < 2));
      end
      if (code == 0) begin
         stack[mdepth] = f;
         mdepth++;
      end else if (code == 1) begin
         mdepth--;
      end
      tick();
      chk({nm, "_depth"}, 240'(depth), 240'(mdepth));
      chk({nm, "_done_pulse"}, 240'(done), 240'(0));
      chk({nm, "_busy_after"}, 240'(busy), 240'(0));
      chk({nm, "_mem_pending"}, 240'(exp_q.size()), 240'(0));
      chk({nm, "_restore_pending"}, 240'(rq.size()), 240'(0));
      if (code < 2) chk({nm, "_first_access"}, 240'(first_mem_n), 240'(1));
      if (code == 1) chk({nm, "_restore_cycle"}, 240'(restore_n), 240'(RET_LAT));
`ifdef CALL_FRAME_CLEAR_EN
      if (code == 0) chk({nm, "_clear_cycle"}, 240'(restore_n), 240'(16));
`endif
      exp_q.delete();
      rq.delete();
   endtask

   vec_t tbl[$];

   initial begin
      logic [239:0] f;
      logic [11:0]  b;
      int           n;

      tbl.push_back('{1'b1, 1'b0, 16'h1000, 0, 0, "call_1000"});
      tbl.push_back('{1'b0, 1'b1, 16'h0000, 1, 0, "ret_1000"});
      tbl.push_back('{1'b1, 1'b0, 16'hA000, 0, 0, "call_a"});
      tbl.push_back('{1'b1, 1'b0, 16'hB000, 0, 0, "call_b"});
      tbl.push_back('{1'b0, 1'b1, 16'h0000, 1, 0, "ret_b"});
      tbl.push_back('{1'b0, 1'b1, 16'h0000, 1, 0, "ret_a"});
      tbl.push_back('{1'b0, 1'b1, 16'h0000, 3, 0, "ret_empty"});

      rst_n    = 1'b0;
      call_req = 1'b0;
      ret_req  = 1'b0;
      fc_in    = '0;
      cur_n = 0; first_mem_n = -1; restore_n = -1;
      #1;
      chk("reset_depth", 240'(depth), '0);
      chk("reset_busy", 240'(busy), '0);
      chk("reset_done", 240'({done, err_overflow, err_underflow, fc_restore}), '0);
      chk("reset_fc_out", fc_out, '0);
      chk("reset_mem", 240'({mem_we, mem_re, mem_addr}), '0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      foreach (tbl[i]) run_op(tbl[i].c, tbl[i].r, tbl[i].seed, tbl[i].code, tbl[i].pulse_at, tbl[i].name);

      for (int i = 0; i < MAXF; i++) run_op(1'b1, 1'b0, 16'h2000 + 16'(i * 16), 0, 0, "fill");
      run_op(1'b1, 1'b0, 16'h3000, 2, 0, "call_full");
      for (int i = 0; i < MAXF - 1; i++) run_op(1'b0, 1'b1, 16'h0000, 1, 0, "drain");
      run_op(1'b1, 1'b1, 16'hC000, 0, 0, "call_ret_both");
      run_op(1'b1, 1'b0, 16'hD000, 0, 5, "ret_during_busy");
      repeat (4) tick();
      chk("ignored_ret_depth", 240'(depth), 240'(mdepth));

      // reset while SAVE is driving word 7: the write strobe must vanish without a clock edge
      f = mk_frame(16'hE000);
      b = BASE + 12'(15 * mdepth);
      for (int k = 0; k < 15; k++) exp_q.push_back('{1'b1, b + 12'(k), f[16*k +: 16]});
      first_mem_n = -1; restore_n = -1; cur_n = 0;
      call_req = 1'b1;
      fc_in    = f;
      tick();
      call_req = 1'b0;
      n = 0;
      while (exp_q.size() > 7 && n < 30) begin
         tick();
         n++;
      end
      chk("rst_word7_addr", 240'(mem_addr), 240'(b + 12'd7));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mem_we", 240'(mem_we), '0);
      chk("rst_mem_addr", 240'(mem_addr), '0);
      chk("rst_depth", 240'(depth), '0);
      chk("rst_busy", 240'(busy), '0);
      exp_q.delete();
      mdepth = 0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      run_op(1'b0, 1'b1, 16'h0000, 3, 0, "ret_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
